reg_bank_arbiter: RTL and testbench



---
 rtl/reg_bank_arbiter_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 28 ++
 rtl/reg_bank_arbiter.sv | 146 ++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and constants for the register-bank arbiter.
package reg_bank_arbiter_pkg;

  // IDLE accepts a new request; RESP returns the data of the read just issued.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam int NUM_REQ  = 2;
  localparam int REQ_CORE = 0;
  localparam int REQ_DBG  = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. When both requesters are active, the one
// that did not win last time gets the grant. The pointer moves only when
// a grant is actually taken (adv).
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  // Grant selection and pointer advance.
  always_comb begin
    gnt    = req;
    last_d = last_q;
    if (req[0] && req[1]) gnt = last_q ? 2'b01 : 2'b10;
    if (adv && (|gnt)) last_d = gnt[1];
  end

  // Pointer register; resets to 1 so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shares a single-write/dual-read register bank between the core datapath
// and the debug/loader requester. Writes commit in one cycle; reads take
// an issue cycle plus a response cycle.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int REG_BITS = 8,
  parameter int REG_SIZE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*REG_BITS-1:0] req_addr_a,
  input  logic [2*REG_BITS-1:0] req_addr_b,
  input  logic [2*BITS-1:0]     req_wdata,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [BITS-1:0]       rsp_data_a,
  output logic [BITS-1:0]       rsp_data_b,
  output logic                  bank_write_enable,
  output logic [REG_BITS-1:0]   bank_address_a,
  output logic [REG_BITS-1:0]   bank_address_b,
  output logic [REG_BITS-1:0]   bank_write_address,
  output logic [BITS-1:0]       bank_write_data,
  input  logic [BITS-1:0]       bank_data_a,
  input  logic [BITS-1:0]       bank_data_b
);

  state_e              state_q, state_d;
  logic                gidx_q, gidx_d;
  logic                oor_a_q, oor_a_d;
  logic                oor_b_q, oor_b_d;
  logic [REG_BITS-1:0] addr_a_q, addr_a_d;
  logic [REG_BITS-1:0] addr_b_q, addr_b_d;

  logic [1:0]          arb_req, gnt;
  logic                gidx;
  logic [REG_BITS-1:0] sel_a, sel_b;
  logic [BITS-1:0]     sel_wdata;
  logic                sel_write, sel_oor_a, sel_oor_b;

  logic [1:0]          ready_int, rsp_int;
  logic                we_int;
  logic [REG_BITS-1:0] ba_int, bb_int, wa_int;
  logic [BITS-1:0]     wd_int;

  // Requests are only arbitrated while the bank is free.
  assign arb_req = (state_q == IDLE) ? req_valid : 2'b00;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arb_req),
    .adv   (1'b1),
    .gnt   (gnt)
  );

  // Pick the granted requester's fields and classify its addresses.
  always_comb begin
    gidx      = gnt[1];
    sel_a     = gidx ? req_addr_a[2*REG_BITS-1:REG_BITS] : req_addr_a[REG_BITS-1:0];
    sel_b     = gidx ? req_addr_b[2*REG_BITS-1:REG_BITS] : req_addr_b[REG_BITS-1:0];
    sel_wdata = gidx ? req_wdata[2*BITS-1:BITS] : req_wdata[BITS-1:0];
    sel_write = gidx ? req_write[1] : req_write[0];
    sel_oor_a = (int'(sel_a) >= REG_SIZE);
    sel_oor_b = (int'(sel_b) >= REG_SIZE);
  end

  // Next-state and bank drive. Read addresses are captured so the bank
  // keeps seeing them through the response cycle.
  always_comb begin
    state_d   = state_q;
    gidx_d    = gidx_q;
    oor_a_d   = oor_a_q;
    oor_b_d   = oor_b_q;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    ready_int = 2'b00;
    rsp_int   = 2'b00;
    we_int    = 1'b0;
    wa_int    = '0;
    wd_int    = '0;
    ba_int    = addr_a_q;
    bb_int    = addr_b_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          ready_int = gnt;
          if (sel_write) begin
            // Out-of-range writes are accepted but dropped.
            we_int = !sel_oor_a;
            wa_int = sel_a;
            wd_int = sel_wdata;
          end else begin
            ba_int   = sel_a;
            bb_int   = sel_b;
            addr_a_d = sel_a;
            addr_b_d = sel_b;
            oor_a_d  = sel_oor_a;
            oor_b_d  = sel_oor_b;
            gidx_d   = gidx;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        rsp_int[gidx_q] = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and captured-read registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gidx_q   <= 1'b0;
      oor_a_q  <= 1'b0;
      oor_b_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      oor_a_q  <= oor_a_d;
      oor_b_q  <= oor_b_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
    end
  end

  // Everything combinational is held at zero while reset is asserted.
  assign req_ready          = rst_n ? ready_int : 2'b00;
  assign rsp_valid          = rst_n ? rsp_int   : 2'b00;
  assign bank_write_enable  = rst_n & we_int;
  assign bank_address_a     = rst_n ? ba_int : '0;
  assign bank_address_b     = rst_n ? bb_int : '0;
  assign bank_write_address = rst_n ? wa_int : '0;
  assign bank_write_data    = rst_n ? wd_int : '0;
  assign rsp_data_a         = (rst_n && !oor_a_q) ? bank_data_a : '0;
  assign rsp_data_b         = (rst_n && !oor_b_q) ? bank_data_b : '0;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed vector table, randomized run against
// a transaction-level model, and a reset-during-response sequence.
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [15:0] req_addr_a, req_addr_b, req_wdata;
  logic [7:0]  rsp_data_a, rsp_data_b;
  logic        bank_write_enable;
  logic [7:0]  bank_address_a, bank_address_b, bank_write_address, bank_write_data;
  logic [7:0]  bank_data_a, bank_data_b;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.BITS(8), .REG_BITS(8), .REG_SIZE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .bank_write_enable(bank_write_enable),
    .bank_address_a(bank_address_a), .bank_address_b(bank_address_b),
    .bank_write_address(bank_write_address), .bank_write_data(bank_write_data),
    .bank_data_a(bank_data_a), .bank_data_b(bank_data_b)
  );

  // Register bank: 2 registers, registered read ports, a write cycle holds
  // the read data. Out-of-range reads return 0x77 so masking is visible.
  logic [7:0] bregs [2];
  initial begin
    bregs[0] = 8'h00; bregs[1] = 8'h00;
    bank_data_a = 8'h00; bank_data_b = 8'h00;
  end
  always @(posedge clk) begin
    if (bank_write_enable) begin
      if (bank_write_address < 8'd2) bregs[bank_write_address[0]] <= bank_write_data;
    end else begin
      bank_data_a <= (bank_address_a < 8'd2) ? bregs[bank_address_a[0]] : 8'h77;
      bank_data_b <= (bank_address_b < 8'd2) ? bregs[bank_address_b[0]] : 8'h77;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [1:0] v, w;
    logic [7:0] a0, b0, a1, b1, d0, d1;
    logic [1:0] e_rdy;
    logic       e_we;
    logic [1:0] e_rsp;
    logic       chk_d;
    logic [7:0] e_da, e_db;
  } vec_t;

  function automatic vec_t mk(logic [1:0] v, logic [1:0] w, logic [7:0] a0, logic [7:0] b0,
                              logic [7:0] a1, logic [7:0] b1, logic [7:0] d0, logic [7:0] d1,
                              logic [1:0] e_rdy, logic e_we, logic [1:0] e_rsp,
                              logic chk_d, logic [7:0] e_da, logic [7:0] e_db);
    vec_t t;
    t.v = v; t.w = w; t.a0 = a0; t.b0 = b0; t.a1 = a1; t.b1 = b1; t.d0 = d0; t.d1 = d1;
    t.e_rdy = e_rdy; t.e_we = e_we; t.e_rsp = e_rsp; t.chk_d = chk_d; t.e_da = e_da; t.e_db = e_db;
    return t;
  endfunction

  // Transaction-level reference state for the random run.
  logic [7:0] mem [2];
  logic       m_last, m_busy, m_preq;
  logic [7:0] m_pa, m_pb;

  function automatic logic [7:0] rd(logic [7:0] a);
    return (a < 8'd2) ? mem[a[0]] : 8'h00;
  endfunction

  vec_t tbl [15];
  logic [1:0] r_v, r_w, hold, e_rdy, e_rsp;
  logic [7:0] r_a [2];
  logic [7:0] r_b [2];
  logic [7:0] r_d [2];
  logic       g, e_we;

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11; req_write = 2'b11;
    req_addr_a = 16'h0101; req_addr_b = 16'h0101; req_wdata = 16'hFFFF;

    // Reset: outputs held low even with requests pending.
    repeat (2) @(posedge clk);
    #4;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_we", bank_write_enable, 1'b0);
    chk("rst_addr_a", bank_address_a, 8'h00);
    chk("rst_addr_b", bank_address_b, 8'h00);
    chk("rst_data_a", rsp_data_a, 8'h00);
    chk("rst_data_b", rsp_data_b, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 2'b00;

    // Directed vectors, one row per cycle.
    tbl[0]  = mk(2'b01, 2'b01, 8'd1, 8'd0, 8'd0, 8'd0, 8'hA5, 8'h00, 2'b01, 1'b1, 2'b00, 1'b0, 8'h00, 8'h00);
    tbl[1]  = mk(2'b01, 2'b00, 8'd1, 8'd0, 8'd0, 8'd0, 8'h00, 8'h00, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00);
    tbl[2]  = mk(2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00, 8'h00, 2'b00, 1'b0, 2'b01, 1'b1, 8'hA5, 8'h00);
    tbl[3]  = mk(2'b10, 2'b10, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00, 8'h3C, 2'b10, 1'b1, 2'b00, 1'b0, 8'h00, 8'h00);
    tbl[4]  = mk(2'b01, 2'b00, 8'd0, 8'd1, 8'd0, 8'd0, 8'h00, 8'h00, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00);
    tbl[5]  = mk(2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00, 8'h00, 2'b00, 1'b0, 2'b01, 1'b1, 8'h3C, 8'hA5);
    tbl[6]  = mk(2'b01, 2'b01, 8'd5, 8'd0, 8'd0, 8'd0, 8'hFF, 8'h00, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00);
    tbl[7]  = mk(2'b01, 2'b00, 8'd5, 8'd1, 8'd0, 8'd0, 8'h00, 8'h00, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00);
    tbl[8]  = mk(2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00, 8'h00, 2'b00, 1'b0, 2'b01, 1'b1, 8'h00, 8'hA5);
    tbl[9]  = mk(2'b11, 2'b00, 8'd0, 8'd1, 8'd1, 8'd0, 8'h00, 8'h00, 2'b10, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00);
    tbl[10] = mk(2'b11, 2'b00, 8'd0, 8'd1, 8'd1, 8'd0, 8'h00, 8'h00, 2'b00, 1'b0, 2'b10, 1'b1, 8'hA5, 8'h3C);
    tbl[11] = mk(2'b11, 2'b00, 8'd0, 8'd1, 8'd1, 8'd0, 8'h00, 8'h00, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00);
    tbl[12] = mk(2'b11, 2'b00, 8'd0, 8'd1, 8'd1, 8'd0, 8'h00, 8'h00, 2'b00, 1'b0, 2'b01, 1'b1, 8'h3C, 8'hA5);
    tbl[13] = mk(2'b11, 2'b00, 8'd0, 8'd1, 8'd1, 8'd0, 8'h00, 8'h00, 2'b10, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00);
    tbl[14] = mk(2'b00, 2'b00, 8'd0, 8'd1, 8'd1, 8'd0, 8'h00, 8'h00, 2'b00, 1'b0, 2'b10, 1'b1, 8'hA5, 8'h3C);

    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      req_valid  = tbl[i].v;
      req_write  = tbl[i].w;
      req_addr_a = {tbl[i].a1, tbl[i].a0};
      req_addr_b = {tbl[i].b1, tbl[i].b0};
      req_wdata  = {tbl[i].d1, tbl[i].d0};
      #4;
      chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_we", i), bank_write_enable, tbl[i].e_we);
      chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, tbl[i].e_rsp);
      if (tbl[i].chk_d) begin
        chk($sformatf("vec%0d_data_a", i), rsp_data_a, tbl[i].e_da);
        chk($sformatf("vec%0d_data_b", i), rsp_data_b, tbl[i].e_db);
      end
    end

    // Randomized run against the transaction model.
    mem[0] = 8'h3C; mem[1] = 8'hA5;
    m_last = 1'b1; m_busy = 1'b0; m_preq = 1'b0; m_pa = 8'h00; m_pb = 8'h00;
    hold = 2'b00; r_v = 2'b00; r_w = 2'b00;
    for (int n = 0; n < 2; n++) begin r_a[n] = 8'h00; r_b[n] = 8'h00; r_d[n] = 8'h00; end
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (!hold[n]) begin
          r_v[n] = ($urandom_range(0, 3) != 0);
          r_w[n] = 1'($urandom_range(0, 1));
          r_a[n] = 8'($urandom_range(0, 3));
          r_b[n] = 8'($urandom_range(0, 3));
          r_d[n] = 8'($urandom);
        end
      end
      req_valid  = r_v;
      req_write  = r_w;
      req_addr_a = {r_a[1], r_a[0]};
      req_addr_b = {r_b[1], r_b[0]};
      req_wdata  = {r_d[1], r_d[0]};
      #4;
      g = 1'b0; e_rdy = 2'b00; e_we = 1'b0; e_rsp = 2'b00;
      if (m_busy) begin
        e_rsp = m_preq ? 2'b10 : 2'b01;
      end else if (r_v != 2'b00) begin
        g     = (r_v == 2'b11) ? !m_last : r_v[1];
        e_rdy = g ? 2'b10 : 2'b01;
        e_we  = r_w[g] && (r_a[g] < 8'd2);
      end
      chk($sformatf("rnd%0d_ready", c), req_ready, e_rdy);
      chk($sformatf("rnd%0d_rsp_valid", c), rsp_valid, e_rsp);
      chk($sformatf("rnd%0d_we", c), bank_write_enable, e_we);
      if (e_rsp != 2'b00) begin
        chk($sformatf("rnd%0d_data_a", c), rsp_data_a, m_pa);
        chk($sformatf("rnd%0d_data_b", c), rsp_data_b, m_pb);
      end
      if (e_we) begin
        chk($sformatf("rnd%0d_waddr", c), bank_write_address, r_a[g]);
        chk($sformatf("rnd%0d_wdata", c), bank_write_data, r_d[g]);
      end
      hold = r_v & ~e_rdy;
      if (m_busy) m_busy = 1'b0;
      else if (r_v != 2'b00) begin
        m_last = g;
        if (r_w[g]) begin
          if (r_a[g] < 8'd2) mem[r_a[g][0]] = r_d[g];
        end else begin
          m_busy = 1'b1; m_preq = g; m_pa = rd(r_a[g]); m_pb = rd(r_b[g]);
        end
      end
    end

    // Reset pulse while a read response is due.
    @(posedge clk); #1; req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b01; req_write = 2'b00; req_addr_a = 16'h0100; req_addr_b = 16'h0001;
    #4;
    chk("rr_issue_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 2'b00;
    #4;
    chk("rr_rst_rsp_valid", rsp_valid, 2'b00);
    chk("rr_rst_data_a", rsp_data_a, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 2'b11;
    #4;
    chk("rr_post_rsp_valid", rsp_valid, 2'b00);
    chk("rr_post_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #4;
    chk("rr_post_rsp", rsp_valid, 2'b01);
    chk("rr_post_data_a", rsp_data_a, mem[0]);
    chk("rr_post_data_b", rsp_data_b, mem[1]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
